fib_c: RTL and testbench

FIB_C -- requirements
Module: fib_c

---
 rtl/fib_pkg.sv | 7 +
 rtl/fib_c.sv | 57 +++++
 tb/tb_fib_c.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci term generator: default width and the
// two seed terms loaded on reset and on restart.
package fib_pkg;
    localparam int FIB_WIDTH_DEF = 4;
    localparam int FIB_SEED0     = 0;
    localparam int FIB_SEED1     = 1;
endpackage

// File: rtl/fib_c.sv
// Free-running Fibonacci term generator. On overflow it either restarts from
// the seeds (RESTART_EN = 1) or saturates at the largest representable term.
module fib_c
    import fib_pkg::*;
#(
    parameter int WIDTH      = FIB_WIDTH_DEF,
    parameter bit RESTART_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("fib_c: WIDTH must be within 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             restart_pending;
    logic [WIDTH:0]   sum;
    logic             carry;

    assign sum   = {1'b0, cur} + {1'b0, nxt};
    assign carry = sum[WIDTH];
    assign out   = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur             <= WIDTH'(FIB_SEED0);
            nxt             <= WIDTH'(FIB_SEED1);
            restart_pending <= 1'b0;
        end else if (restart_pending) begin
            cur             <= WIDTH'(FIB_SEED0);
            nxt             <= WIDTH'(FIB_SEED1);
            restart_pending <= 1'b0;
        end else if (carry) begin
            // nxt is held, so in saturate mode cur latches the last term forever
            cur             <= nxt;
            restart_pending <= RESTART_EN;
        end else begin
            cur <= nxt;
            nxt <= sum[WIDTH-1:0];
        end
    end

    // The sequence is monotonic between restarts, so cur can never pass nxt.
    always_ff @(posedge clk) begin
        if (!rst && !restart_pending) begin
            assert (cur <= nxt)
            else $error("fib_c: out (%0d) exceeds nxt (%0d)", cur, nxt);
        end
    end

endmodule

// File: tb/tb_fib_c.sv
// Scoreboard bench: three generator configurations share one reset stream;
// a reference built from the list of Fibonacci terms predicts every output.
`timescale 1ns/1ps
module tb_fib_c;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] out4;
    logic [7:0] out8;
    logic [3:0] outs;

    always #1 clk = ~clk;

    fib_c #(.WIDTH(4), .RESTART_EN(1'b1)) dut4 (.clk(clk), .rst(rst), .out(out4));
    fib_c #(.WIDTH(8), .RESTART_EN(1'b1)) dut8 (.clk(clk), .rst(rst), .out(out8));
    fib_c #(.WIDTH(4), .RESTART_EN(1'b0)) duts (.clk(clk), .rst(rst), .out(outs));

    typedef struct {
        int e4;
        int e8;
        int es;
    } exp_t;

    exp_t q[$];
    int   seq4[$];
    int   seq8[$];
    int   idx4, idx8, idxs;
    int   tests  = 0;
    int   failed = 0;

    // All Fibonacci terms that fit in w bits, starting 0,1.
    function automatic void build(input int w, output int s[$]);
        longint a, b, t;
        s = {};
        a = 0;
        b = 1;
        while (a < (longint'(1) << w)) begin
            s.push_back(int'(a));
            t = a + b;
            a = b;
            b = t;
        end
    endfunction

    // Present rst for the coming rising edge and queue what that edge must produce.
    task automatic drive(input bit r);
        exp_t e;
        rst = r;
        if (r) begin
            idx4 = 0;
            idx8 = 0;
            idxs = 0;
        end else begin
            idx4 = (idx4 + 1) % seq4.size();
            idx8 = (idx8 + 1) % seq8.size();
            idxs = (idxs + 1 < seq4.size()) ? idxs + 1 : seq4.size() - 1;
        end
        e.e4 = seq4[idx4];
        e.e8 = seq8[idx8];
        e.es = seq4[idxs];
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_w4_restart", int'(out4), e.e4);
                check("out_w8_restart", int'(out8), e.e8);
                check("out_w4_saturate", int'(outs), e.es);
            end
        end
    end

    initial begin : stim
        int guard;
        build(4, seq4);
        build(8, seq8);
        idx4 = 0;
        idx8 = 0;
        idxs = 0;

        // reset hold for three edges
        for (int i = 0; i < 3; i++) drive(1'b1);

        // long free run: covers the W4 wrap, W8 233->0->1, and saturation at 13
        for (int i = 0; i < 40; i++) drive(1'b0);

        // mid-run reset while the 4-bit output shows 5
        guard = 0;
        while (seq4[idx4] != 5 && guard < 20) begin
            drive(1'b0);
            guard++;
        end
        check("reach_out_5", seq4[idx4], 5);
        drive(1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0);

        // reset landing on the overflow and restart steps
        for (int k = 6; k <= 7; k++) begin
            drive(1'b1);
            for (int i = 0; i < k; i++) drive(1'b0);
            drive(1'b1);
            for (int i = 0; i < 4; i++) drive(1'b0);
        end

        // random reset stream
        for (int i = 0; i < 400; i++) drive($urandom_range(0, 15) == 0);
        for (int i = 0; i < 20; i++) drive(1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
